// File: rtl/kt11_pkg.sv
// Shared types and constants for the KT11 Unibus slave-cycle sequencer.
// Holds the state encoding, Unibus C1/C0 cycle codes and the default 200 ns phase length.
package kt11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IGNORE,
        ST_DESKEW,
        ST_ACCESS,
        ST_HOLD
    } kt11_state_e;

    localparam logic [1:0] BC_DATI  = 2'b00;
    localparam logic [1:0] BC_DATIP = 2'b01;
    localparam logic [1:0] BC_DATO  = 2'b10;
    localparam logic [1:0] BC_DATOB = 2'b11;

    // 200 ns at a 50 MHz clock.
    localparam int KT11_200NS_CYC = 10;

    // Byte-lane strobes for a write, returned as {high, low}.
    function automatic logic [1:0] lane_sel(input logic byte_op, input logic ba0);
        if (!byte_op) begin
            return 2'b11;
        end
        return ba0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/kt11_slave_seq_if.sv
// Unibus slave-side signal bundle between the bus interface and the KT11 sequencer.
// Purely wiring: no latency, no flow control beyond the MSYN/SSYN handshake it carries.
interface kt11_slave_seq_if;
    logic       msyn;
    logic [1:0] bc;
    logic       ba0;
    logic       kt_hit;
    logic       adrs;
    logic       int_adrs;
    logic       no_msyn;
    logic       rd_en;
    logic       wr_low;
    logic       wr_high;
    logic       ssyn;
    logic       busy;

    modport slave (
        input  msyn, bc, ba0, kt_hit,
        output adrs, int_adrs, no_msyn, rd_en, wr_low, wr_high, ssyn, busy
    );

    modport master (
        output msyn, bc, ba0, kt_hit,
        input  adrs, int_adrs, no_msyn, rd_en, wr_low, wr_high, ssyn, busy
    );
endinterface

// File: rtl/kt11_phase_timer.sv
// Loadable down counter timing the deskew and access phases; saturates at zero.
// Load takes effect next cycle; no backpressure, enable simply freezes the count.
module kt11_phase_timer #(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    input  logic            en,
    output logic [CNTW-1:0] cnt,
    output logic            zero
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/kt11_slave_seq.sv
// Unibus slave-cycle sequencer for the KT11 register file: claim, deskew, access, SSYN.
// adrs one cycle after MSYN rise, strobe DESKEW_CYC+ACCESS_CYC after; MSYN low aborts, no backpressure.
module kt11_slave_seq
    import kt11_pkg::*;
#(
    parameter int DESKEW_CYC = KT11_200NS_CYC,
    parameter int ACCESS_CYC = KT11_200NS_CYC,
    parameter int CNTW       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    kt11_slave_seq_if.slave       bus
);

    localparam logic [CNTW-1:0] DESKEW_LD = CNTW'(DESKEW_CYC - 1);
    localparam logic [CNTW-1:0] ACCESS_LD = CNTW'(ACCESS_CYC - 1);

    kt11_state_e state_q, state_d;
    logic msyn_q, msyn_q_d;
    logic adrs_q, adrs_d;
    logic int_adrs_q, int_adrs_d;
    logic rd_en_q, rd_en_d;
    logic wr_low_q, wr_low_d;
    logic wr_high_q, wr_high_d;
    logic ssyn_q, ssyn_d;
    logic wr_q, wr_d;
    logic byte_op_q, byte_op_d;
    logic ba0_q, ba0_d;

    logic            rise;
    logic            tmr_load;
    logic            tmr_en;
    logic [CNTW-1:0] tmr_val;
    logic [CNTW-1:0] tmr_cnt;
    logic            tmr_zero;
    logic [1:0]      lanes;

    kt11_phase_timer #(.CNTW(CNTW)) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (init),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    assign rise = bus.msyn & ~msyn_q;

    always_comb begin
        state_d    = state_q;
        msyn_q_d   = bus.msyn;
        adrs_d     = 1'b0;
        int_adrs_d = 1'b0;
        rd_en_d    = 1'b0;
        wr_low_d   = 1'b0;
        wr_high_d  = 1'b0;
        ssyn_d     = 1'b0;
        wr_d       = wr_q;
        byte_op_d  = byte_op_q;
        ba0_d      = ba0_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_val    = '0;
        lanes      = 2'b00;

        // Strobes are registered, so they are raised on the edge entering the
        // last access cycle; every branch that does so requires MSYN still high.
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    if (bus.kt_hit) begin
                        state_d  = ST_DESKEW;
                        adrs_d   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = DESKEW_LD;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
            end
            ST_IGNORE: begin
                if (!bus.msyn) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DESKEW: begin
                if (!bus.msyn) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d    = ST_ACCESS;
                    int_adrs_d = 1'b1;
                    wr_d       = bus.bc[1];
                    byte_op_d  = bus.bc[0];
                    ba0_d      = bus.ba0;
                    rd_en_d    = ~bus.bc[1];
                    tmr_load   = 1'b1;
                    tmr_val    = ACCESS_LD;
                    if ((ACCESS_CYC == 1) && bus.bc[1]) begin
                        lanes = lane_sel(bus.bc[0], bus.ba0);
                    end
                end else begin
                    adrs_d = 1'b1;
                    tmr_en = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!bus.msyn) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d    = ST_HOLD;
                    ssyn_d     = 1'b1;
                    int_adrs_d = 1'b1;
                    rd_en_d    = ~wr_q;
                end else begin
                    int_adrs_d = 1'b1;
                    rd_en_d    = ~wr_q;
                    tmr_en     = 1'b1;
                    if (wr_q && (tmr_cnt == CNTW'(1))) begin
                        lanes = lane_sel(byte_op_q, ba0_q);
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.msyn) begin
                    state_d = ST_IDLE;
                end else begin
                    ssyn_d     = 1'b1;
                    int_adrs_d = 1'b1;
                    rd_en_d    = ~wr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_low_d  = lanes[0];
        wr_high_d = lanes[1];

        if (init) begin
            state_d    = ST_IDLE;
            msyn_q_d   = 1'b0;
            adrs_d     = 1'b0;
            int_adrs_d = 1'b0;
            rd_en_d    = 1'b0;
            wr_low_d   = 1'b0;
            wr_high_d  = 1'b0;
            ssyn_d     = 1'b0;
            wr_d       = 1'b0;
            byte_op_d  = 1'b0;
            ba0_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            msyn_q     <= 1'b0;
            adrs_q     <= 1'b0;
            int_adrs_q <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_low_q   <= 1'b0;
            wr_high_q  <= 1'b0;
            ssyn_q     <= 1'b0;
            wr_q       <= 1'b0;
            byte_op_q  <= 1'b0;
            ba0_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            msyn_q     <= msyn_q_d;
            adrs_q     <= adrs_d;
            int_adrs_q <= int_adrs_d;
            rd_en_q    <= rd_en_d;
            wr_low_q   <= wr_low_d;
            wr_high_q  <= wr_high_d;
            ssyn_q     <= ssyn_d;
            wr_q       <= wr_d;
            byte_op_q  <= byte_op_d;
            ba0_q      <= ba0_d;
        end
    end

    assign bus.adrs     = adrs_q;
    assign bus.int_adrs = int_adrs_q;
    assign bus.no_msyn  = adrs_q | int_adrs_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.wr_low   = wr_low_q;
    assign bus.wr_high  = wr_high_q;
    assign bus.ssyn     = ssyn_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_kt11_slave_seq.sv
// Directed bench for kt11_slave_seq: per-cycle expected outputs from the bus timing table are queued
// as stimulus is driven and checked against the DUT on the falling edge.
module tb_kt11_slave_seq;
    import kt11_pkg::*;

    localparam int DSK = 10;
    localparam int ACC = 10;

    typedef struct packed {
        logic adrs;
        logic int_adrs;
        logic no_msyn;
        logic rd_en;
        logic wr_low;
        logic wr_high;
        logic ssyn;
        logic busy;
    } ov_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic init = 1'b0;

    kt11_slave_seq_if s();

    kt11_slave_seq #(.DESKEW_CYC(DSK), .ACCESS_CYC(ACC), .CNTW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .bus   (s)
    );

    always #5 clk = ~clk;

    ov_t   exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;

    // Expected outputs d cycles after the rise cycle; m = cycle msyn first low,
    // clr = first cycle forced clear by init/reset (-1 if none).
    function automatic ov_t model(logic [1:0] bc, logic hit, logic ba0, int d, int m, int clr);
        ov_t o = '0;
        if (d < 1 || d > m || (clr >= 0 && d >= clr)) return o;
        o.busy = 1'b1;
        if (!hit) return o;
        o.adrs     = (d <= DSK);
        o.int_adrs = (d > DSK);
        o.no_msyn  = 1'b1;
        o.rd_en    = !bc[1] && (d > DSK);
        o.ssyn     = (d > DSK + ACC);
        if (bc[1] && d == DSK + ACC) begin
            o.wr_low  = !bc[0] || !ba0;
            o.wr_high = !bc[0] || ba0;
        end
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ov_t   e;
            ov_t   obs;
            string t;
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            obs = '{s.adrs, s.int_adrs, s.no_msyn, s.rd_en, s.wr_low, s.wr_high, s.ssyn, s.busy};
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s t=%0t observed=%b expected=%b (adrs,int,no_msyn,rd,wl,wh,ssyn,busy)",
                       t, $time, obs, e);
            end
        end
    end

    task automatic run_txn(input logic [1:0] bc_i, input logic hit, input logic ba0_i,
                           input int m, input int tail, input int init_at, input int rst_at,
                           input string tag);
        int clr;
        clr = -1;
        if (init_at >= 0) clr = init_at + 1;
        if (rst_at >= 0) clr = rst_at;
        for (int d = 0; d <= m + tail; d++) begin
            @(posedge clk);
            #1;
            s.msyn   = (d < m);
            s.bc     = bc_i;
            s.ba0    = ba0_i;
            s.kt_hit = (d == 0) ? hit : !hit;
            init     = (d == init_at);
            reset    = !(rst_at >= 0 && d >= rst_at && d <= rst_at + 1);
            exp_q.push_back(model(bc_i, hit, ba0_i, d, m, clr));
            tag_q.push_back($sformatf("%s_d%0d", tag, d));
        end
        init  = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        s.msyn   = 1'b0;
        s.bc     = BC_DATI;
        s.ba0    = 1'b0;
        s.kt_hit = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back('0);
            tag_q.push_back("reset");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back('0);
        tag_q.push_back("post_reset");

        run_txn(BC_DATO,  1'b1, 1'b0, 30, 2, -1, -1, "dato_word");
        run_txn(BC_DATOB, 1'b1, 1'b1, 30, 2, -1, -1, "datob_hi");
        run_txn(BC_DATOB, 1'b1, 1'b0, 30, 2, -1, -1, "datob_lo");
        run_txn(BC_DATI,  1'b1, 1'b0, 30, 2, -1, -1, "dati");
        run_txn(BC_DATIP, 1'b1, 1'b1, 25, 2, -1, -1, "datip");
        run_txn(BC_DATO,  1'b0, 1'b0, 12, 2, -1, -1, "ignore");
        run_txn(BC_DATO,  1'b1, 1'b0, 15, 4, -1, -1, "abort15");
        run_txn(BC_DATO,  1'b1, 1'b0, 30, 2, -1, -1, "after_abort");
        run_txn(BC_DATO,  1'b1, 1'b0, 19, 3, -1, -1, "abort19");
        run_txn(BC_DATO,  1'b1, 1'b0, 19, 3, 18, -1, "init18");
        run_txn(BC_DATOB, 1'b1, 1'b1, 30, 2, -1, -1, "after_init");
        run_txn(BC_DATI,  1'b1, 1'b0, 19, 3, -1, 18, "reset18");
        run_txn(BC_DATO,  1'b1, 1'b0, 30, 2, -1, -1, "after_reset");

        repeat (3) @(posedge clk);
        #1;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL drain observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kt11_slave_seq.md
# kt11_slave_seq

Unibus slave-cycle sequencer for the KT11 memory-management register file (PARs, PDRs, SR0, SR2). It turns the master's MSYN/C1/C0 handshake into claim, deskew, access and SSYN phases, and generates the read-enable and byte-lane write strobes the KT11 datapath consumes. It replaces the chain of free-running edge detectors and 200 ns delay cells with one counter-driven state machine. It sits between the bus interface (MSYN, C1/C0, address decode hit) and the KT11 register array.

## Interface
- DESKEW_CYC, 10: cycles from MSYN rise to internal-address phase (200 ns at 50 MHz); legal 1..255
- ACCESS_CYC, 10: cycles of register access before SSYN; legal 1..255
- CNTW, 8: phase counter width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- init  in  1  bus INIT, synchronous clear, same effect as reset
- msyn  in  1  master sync, already synchronised to clk
- bc  in  2  {C1,C0}: 00 DATI, 01 DATIP, 10 DATO, 11 DATOB
- ba0  in  1  byte address bit 0
- kt_hit  in  1  combinational decode: address is a KT11 register
- adrs  out  1  address claimed (deskew phase)
- int_adrs  out  1  internal address phase active
- no_msyn  out  1  adrs | int_adrs
- rd_en  out  1  drive register data onto the bus
- wr_low  out  1  one-cycle write strobe, bits 7:0
- wr_high  out  1  one-cycle write strobe, bits 15:8
- ssyn  out  1  slave sync
- busy  out  1  state != IDLE

## Operation
- States: IDLE, IGNORE, DESKEW, ACCESS, HOLD.
- msyn_q is a registered copy of msyn. rise = msyn & ~msyn_q.
- IDLE: on rise with kt_hit=1 → DESKEW, cnt=DESKEW_CYC-1, adrs=1. On rise with kt_hit=0 → IGNORE. kt_hit is sampled only in the rise cycle.
- IGNORE: no outputs asserted; → IDLE when msyn=0.
- DESKEW: when cnt=0 → ACCESS, cnt=ACCESS_CYC-1, adrs=0, int_adrs=1. On this transition, latch bc into wr=bc[1], byte=bc[0], and latch ba0.
- ACCESS: rd_en=1 when wr=0. When cnt=0 and wr=1, pulse the lanes for exactly one cycle:
  - word write (byte=0): wr_low and wr_high
  - byte write, ba0=0: wr_low only
  - byte write, ba0=1: wr_high only
- ACCESS at cnt=0 → HOLD with ssyn=1.
- HOLD: ssyn=1, int_adrs=1, rd_en held for reads; → IDLE when msyn=0.
- msyn=0 in DESKEW or ACCESS → IDLE. This aborts the cycle: no write strobe, ssyn never asserted.
- DATIP is treated as DATI; no read-modify-write lock is kept.
- The counter decrements once per cycle in DESKEW and ACCESS and is frozen otherwise. It never underflows.

## Timing
- Reset/init values: state=IDLE, cnt=0, msyn_q=0, and every output 0.
- Let N be the rise cycle:
  - adrs=1 over cycles N+1 .. N+DESKEW_CYC
  - int_adrs=1 from N+DESKEW_CYC+1
  - write strobe at N+DESKEW_CYC+ACCESS_CYC
  - ssyn=1 from N+DESKEW_CYC+ACCESS_CYC+1
- Release: if msyn is first seen low in cycle M, all outputs are 0 from cycle M+1.
- MSYN falling and the last ACCESS cycle coinciding: the abort wins, so no strobe and no ssyn.
- msyn held high after HOLD exits cannot happen; a new cycle needs a fresh rise, since msyn_q blocks a retrigger.
- init asserted mid-cycle: the next cycle is IDLE and any pending strobe is dropped.
- Async reset drops outputs immediately, without waiting for a clock edge.
- Combinational outputs (no_msyn, busy) are decoded from registered state only, with no input-to-output paths.

## Structure
- Shared package kt11_pkg holds:
  - the state enum
  - bus cycle codes BC_DATI=2'b00, BC_DATIP=2'b01, BC_DATO=2'b10, BC_DATOB=2'b11
  - the default 200 ns cycle-count constant
- One sub-module, kt11_phase_timer: a loadable CNTW-bit down counter with load, enable and zero outputs. The FSM lives in kt11_slave_seq.

## Test plan
- Word DATO to PAR, DESKEW=ACCESS=10, rise at cycle 0:
  - adrs=1 over cycles 1-10
  - wr_low=wr_high=1 only at cycle 20
  - ssyn=1 from cycle 21
  - msyn low at cycle 30 → all outputs 0 at cycle 31
- DATOB, ba0=1: wr_high pulses once at cycle 20 and wr_low stays 0. With ba0=0 the behaviour mirrors this.
- DATI with kt_hit=1:
  - rd_en=1 from cycle 11 until one cycle after msyn falls
  - no write strobes
  - ssyn at cycle 21
- kt_hit=0 at rise: state IGNORE, every output stays 0, and busy=1 until msyn falls.
- Abort: msyn drops at cycle 15 during DATO → outputs 0 at cycle 16, no strobe, no ssyn. A new rise at cycle 20 then sequences normally.
- init at cycle 18, and separately reset low at cycle 18: outputs clear (reset with no clock edge), state IDLE. A subsequent rise starts a clean cycle.
